// File: rtl/pcmcia_pkg.sv
// ----------------------------------------------------------------------------
// pcmcia_pkg
// Shared definitions for the PCMCIA/CAM bus arbiter: bus widths, default
// access timing, the access-sequencer state encoding and the captured
// request bundle.
// ----------------------------------------------------------------------------
package pcmcia_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    // Default access timing in clk_100mhz cycles.
    localparam int T_SETUP_DEF     = 3;
    localparam int T_STROBE_DEF    = 10;
    localparam int T_HOLD_DEF      = 2;
    localparam int TIMEOUT_CYC_DEF = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT,
        ST_HOLD
    } arb_state_e;

    // One master's access, captured at grant time.
    typedef struct packed {
        logic              write;
        logic              attr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // A phase lasting n cycles loads n-1 and ends on the cycle the count is 0.
    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/pcmcia_rr_arbiter.sv
// ----------------------------------------------------------------------------
// pcmcia_rr_arbiter
// Two-way round-robin grant. On a tie the requester that did not win last
// time is granted; a lone requester always wins. last_grant only moves when
// the grant is actually taken (accept).
//
// Ports:
//   clk_100mhz  system clock
//   rst         synchronous active-high reset (last_grant -> 1)
//   req[1:0]    request vector, bit N = requester N
//   accept      grant taken this cycle, update last_grant
//   grant[1:0]  one-hot combinational grant (0 when no request)
// ----------------------------------------------------------------------------
module pcmcia_rr_arbiter (
    input  logic       clk_100mhz,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/pcmcia_bus_arbiter.sv
// ----------------------------------------------------------------------------
// pcmcia_bus_arbiter
// Shares the 16-bit PCMCIA/CAM bus between requester 0 (CAM init / CIS
// config) and requester 1 (EN50221 link-layer port). Every access runs
// SETUP -> STROBE -> (WAIT) -> HOLD with programmable cycle counts. All pad
// outputs are registered from the next-state decode so they are glitch free
// and line up exactly with the state register.
//
// Optional feature macro: PCMCIA_ARB_TIMEOUT_EN bounds WAIT to TIMEOUT_CYC
// cycles and reports the abort through err. Without it WAIT is unbounded
// and err is 0.
//
// Ports:
//   clk_100mhz, rst            clock, synchronous active-high reset
//   reqN_valid/write/attr/addr/wdata   request from master N (held to ack)
//   reqN_ack, reqN_done        one-cycle accept / completion pulses
//   rdata, err                 read data and timeout flag, valid with done
//   bus_addr, bus_wdata, bus_data_oe, bus_rdata   pad address/data
//   ce1_n, ce2_n, oe_n, we_n, reg_n                 pad strobes
//   wait_n                     asynchronous card wait
//   busy                       high whenever an access is in progress
// ----------------------------------------------------------------------------
module pcmcia_bus_arbiter
    import pcmcia_pkg::*;
#(
    parameter int T_SETUP     = T_SETUP_DEF,   // min 1
    parameter int T_STROBE    = T_STROBE_DEF,  // min 1
    parameter int T_HOLD      = T_HOLD_DEF,    // min 1
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk_100mhz,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic              req0_attr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic              req1_attr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req0_ack,
    output logic              req1_ack,
    output logic              req0_done,
    output logic              req1_done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_data_oe,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              ce1_n,
    output logic              ce2_n,
    output logic              oe_n,
    output logic              we_n,
    output logic              reg_n,
    input  logic              wait_n,
    output logic              busy
);

    arb_state_e       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    bus_req_t         cur, cur_d;
    bus_req_t         req0_bundle, req1_bundle;
    logic             owner, owner_d;
    logic [1:0]       grant;
    logic             accept;
    logic             capture;
    logic             wait_meta, wait_s;
    logic             active_d, strobe_on_d, done_d;
`ifdef PCMCIA_ARB_TIMEOUT_EN
    logic             timeout;
    logic             timed_out;
`endif

    assign req0_bundle = '{write: req0_write, attr: req0_attr, addr: req0_addr, wdata: req0_wdata};
    assign req1_bundle = '{write: req1_write, attr: req1_attr, addr: req1_addr, wdata: req1_wdata};

    assign req0_ack = accept & grant[0];
    assign req1_ack = accept & grant[1];

    pcmcia_rr_arbiter u_rr (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .req        ({req1_valid, req0_valid}),
        .accept     (accept),
        .grant      (grant)
    );

    // Two-flop synchroniser; resets to "ready" so a fresh access never sees a
    // stale wait from before reset.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            wait_meta <= 1'b1;
            wait_s    <= 1'b1;
        end else begin
            wait_meta <= wait_n;
            wait_s    <= wait_meta;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;   // saturates at 0
        cur_d   = cur;
        owner_d = owner;
        accept  = 1'b0;
        capture = 1'b0;
`ifdef PCMCIA_ARB_TIMEOUT_EN
        timeout = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                // ack is combinational, so it is masked while reset is held.
                if (!rst && (grant != 2'b00)) begin
                    accept  = 1'b1;
                    cur_d   = grant[1] ? req1_bundle : req0_bundle;
                    owner_d = grant[1];
                    state_d = ST_SETUP;
                    cnt_d   = cnt_load(T_SETUP);
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = cnt_load(T_STROBE);
                end
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    if (wait_s) begin
                        capture = ~cur.write;
                        state_d = ST_HOLD;
                        cnt_d   = cnt_load(T_HOLD);
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = cnt_load(TIMEOUT_CYC);
                    end
                end
            end
            ST_WAIT: begin
                if (wait_s) begin
                    capture = ~cur.write;
                    state_d = ST_HOLD;
                    cnt_d   = cnt_load(T_HOLD);
                end
`ifdef PCMCIA_ARB_TIMEOUT_EN
                else if (cnt == '0) begin
                    // Abort: strobe released, rdata left untouched.
                    timeout = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = cnt_load(T_HOLD);
                end
`endif
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        active_d    = (state_d != ST_IDLE);
        strobe_on_d = (state_d == ST_STROBE) || (state_d == ST_WAIT);
        // done is registered, so it is raised for the last HOLD cycle.
        done_d      = (state_d == ST_HOLD) && (cnt_d == '0);
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cur         <= '0;
            owner       <= 1'b0;
            busy        <= 1'b0;
            ce1_n       <= 1'b1;
            ce2_n       <= 1'b1;
            oe_n        <= 1'b1;
            we_n        <= 1'b1;
            reg_n       <= 1'b1;
            bus_data_oe <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            rdata       <= '0;
            req0_done   <= 1'b0;
            req1_done   <= 1'b0;
            err         <= 1'b0;
`ifdef PCMCIA_ARB_TIMEOUT_EN
            timed_out   <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            cur         <= cur_d;
            owner       <= owner_d;
            busy        <= active_d;
            ce1_n       <= ~active_d;          // always a 16-bit access
            ce2_n       <= ~active_d;
            reg_n       <= ~(active_d & cur_d.attr);
            oe_n        <= ~(strobe_on_d & ~cur_d.write);
            we_n        <= ~(strobe_on_d & cur_d.write);
            bus_data_oe <= active_d & cur_d.write;
            if (accept) begin
                bus_addr  <= cur_d.addr;
                bus_wdata <= cur_d.wdata;
            end
            if (capture) begin
                rdata <= bus_rdata;
            end
            req0_done   <= done_d & ~owner_d;
            req1_done   <= done_d & owner_d;
`ifdef PCMCIA_ARB_TIMEOUT_EN
            if (accept) begin
                timed_out <= 1'b0;
            end else if (timeout) begin
                timed_out <= 1'b1;
            end
            err         <= done_d & (timed_out | timeout);
`else
            err         <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_pcmcia_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_pcmcia_bus_arbiter
// Directed scoreboard bench. The stimulus pushes the expected outcome of each
// access (owner, rdata, err, ack->done latency, strobe-low length, gap after
// the previous done) into a queue; a negedge monitor tracks the bus during
// the access and pops/compares on every reqN_done.
// ----------------------------------------------------------------------------
module tb_pcmcia_bus_arbiter;

    logic        clk_100mhz = 1'b0;
    logic        rst;
    logic        req0_valid, req0_write, req0_attr;
    logic [25:0] req0_addr;
    logic [15:0] req0_wdata;
    logic        req1_valid, req1_write, req1_attr;
    logic [25:0] req1_addr;
    logic [15:0] req1_wdata;
    logic        req0_ack, req1_ack, req0_done, req1_done;
    logic [15:0] rdata;
    logic        err;
    logic [25:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_data_oe;
    logic [15:0] bus_rdata;
    logic        ce1_n, ce2_n, oe_n, we_n, reg_n;
    logic        wait_n;
    logic        busy;

    always #5 clk_100mhz = ~clk_100mhz;

    pcmcia_bus_arbiter #(
        .T_SETUP     (3),
        .T_STROBE    (10),
        .T_HOLD      (2),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk_100mhz  (clk_100mhz),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_write  (req0_write),
        .req0_attr   (req0_attr),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req1_valid  (req1_valid),
        .req1_write  (req1_write),
        .req1_attr   (req1_attr),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req0_ack    (req0_ack),
        .req1_ack    (req1_ack),
        .req0_done   (req0_done),
        .req1_done   (req1_done),
        .rdata       (rdata),
        .err         (err),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_data_oe (bus_data_oe),
        .bus_rdata   (bus_rdata),
        .ce1_n       (ce1_n),
        .ce2_n       (ce2_n),
        .oe_n        (oe_n),
        .we_n        (we_n),
        .reg_n       (reg_n),
        .wait_n      (wait_n),
        .busy        (busy)
    );

    typedef struct {
        int          id;
        bit          wr;
        bit          attr;
        logic [25:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        bit          err;
        int          lat;
        int          slen;
        int          gap;    // -1 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_done  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic push(input int id, input bit wr, input bit attr, input logic [25:0] a,
                        input logic [15:0] wd, input logic [15:0] rd, input bit e,
                        input int lat, input int slen, input int gap);
        exp_t x;
        x = '{id: id, wr: wr, attr: attr, addr: a, wdata: wd, rdata: rd, err: e,
              lat: lat, slen: slen, gap: gap};
        exp_q.push_back(x);
    endtask

    // Called just after a posedge; returns just after a posedge.
    task automatic issue(input int id, input bit wr, input bit attr,
                         input logic [25:0] a, input logic [15:0] d);
        bit got = 1'b0;
        if (id == 0) begin
            req0_write = wr; req0_attr = attr; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
        end else begin
            req1_write = wr; req1_attr = attr; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
        end
        for (int k = 0; k < 1000 && !got; k++) begin
            @(negedge clk_100mhz);
            got = (id == 0) ? req0_ack : req1_ack;
        end
        check($sformatf("ack_req%0d", id), {31'b0, got}, 32'd1);
        @(posedge clk_100mhz); #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_100mhz);
        #1;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(posedge clk_100mhz);
        check("drain", exp_q.size(), 32'd0);
        step(2);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   cyc       = 0;
    int   ack_cyc   = 0;
    int   slen      = 0;
    int   bad       = 0;
    int   gap       = 0;
    int   last_done = -1000;
    bit   active    = 1'b0;
    exp_t cur;
    exp_t e;

    always @(negedge clk_100mhz) begin
        cyc++;
        if (rst) begin
            active = 1'b0;
        end else begin
            if (active && busy) begin
                if (!oe_n || !we_n) slen++;
                if (ce1_n || ce2_n || bus_addr !== cur.addr || reg_n !== ~cur.attr ||
                    bus_data_oe !== cur.wr || (cur.wr && bus_wdata !== cur.wdata) ||
                    (cur.wr && !oe_n) || (!cur.wr && !we_n))
                    bad++;
            end
            if (req0_ack || req1_ack) begin
                ack_cyc = cyc;
                slen    = 0;
                bad     = 0;
                gap     = cyc - last_done;
                active  = (exp_q.size() != 0);
                if (active) cur = exp_q[0];
            end
            if (req0_done || req1_done) begin
                n_done++;
                last_done = cyc;
                check("done_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("done_owner", {30'b0, req1_done, req0_done}, (e.id == 1) ? 32'd2 : 32'd1);
                    check("err", {31'b0, err}, {31'b0, e.err});
                    if (!e.wr) check("rdata", {16'b0, rdata}, {16'b0, e.rdata});
                    check("ack_to_done", cyc - ack_cyc, e.lat);
                    check("strobe_len", slen, e.slen);
                    check("bus_hold", bad, 32'd0);
                    if (e.gap >= 0) check("idle_gap", gap, e.gap);
                end
                active = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    int done_before;

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_write = 0; req0_attr = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_attr = 0; req1_addr = '0; req1_wdata = '0;
        bus_rdata = '0;
        wait_n = 1'b1;
        repeat (4) @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        check("rst_strobes", {27'b0, ce1_n, ce2_n, oe_n, we_n, reg_n}, 32'h1F);
        check("rst_data_oe", {31'b0, bus_data_oe}, 32'd0);
        check("rst_bus_addr", {6'b0, bus_addr}, 32'd0);
        check("rst_bus_wdata", {16'b0, bus_wdata}, 32'd0);
        check("rst_rdata", {16'b0, rdata}, 32'd0);
        check("rst_ctl", {26'b0, req0_ack, req1_ack, req0_done, req1_done, err, busy}, 32'd0);
        @(posedge clk_100mhz); #1;
        rst = 1'b0;
        step(2);

        // Single attribute read from requester 1.
        bus_rdata = 16'h1D55;
        push(1, 0, 1, 26'h000200, 16'h0, 16'h1D55, 0, 15, 10, -1);
        issue(1, 0, 1, 26'h000200, 16'h0);
        drain(200);

        // Contention: last grant was 1, so 0 wins first, then they alternate.
        bus_rdata = 16'h3C3C;
        push(0, 1, 0, 26'h000010, 16'hA001, 16'h0,    0, 15, 10, -1);
        push(1, 0, 1, 26'h000020, 16'h0,    16'h3C3C, 0, 15, 10, 1);
        push(0, 1, 0, 26'h000012, 16'hA002, 16'h0,    0, 15, 10, 1);
        push(1, 0, 1, 26'h000022, 16'h0,    16'h3C3C, 0, 15, 10, 1);
        fork
            begin
                issue(0, 1, 0, 26'h000010, 16'hA001);
                issue(0, 1, 0, 26'h000012, 16'hA002);
            end
            begin
                issue(1, 0, 1, 26'h000020, 16'h0);
                issue(1, 0, 1, 26'h000022, 16'h0);
            end
        join
        drain(300);

        // Single common-memory write from requester 0.
        push(0, 1, 0, 26'h0003F0, 16'h0041, 16'h0, 0, 15, 10, -1);
        issue(0, 1, 0, 26'h0003F0, 16'h0041);
        drain(200);

        // Wait stretch: wait_n low from STROBE cycle 5 (ack+8) for 40 cycles.
        bus_rdata = 16'hBEEF;
        push(0, 0, 0, 26'h001234, 16'h0, 16'hBEEF, 0, 52, 47, -1);
        fork
            issue(0, 0, 0, 26'h001234, 16'h0);
            begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk_100mhz);
                    if (req0_ack) break;
                end
                repeat (8) @(negedge clk_100mhz);
                wait_n = 1'b0;
                repeat (40) @(negedge clk_100mhz);
                wait_n = 1'b1;
            end
        join
        drain(300);

`ifdef PCMCIA_ARB_TIMEOUT_EN
        // Timeout: wait_n stuck low; WAIT lasts 64 cycles, rdata keeps 0xBEEF.
        bus_rdata = 16'h7777;
        wait_n = 1'b0;
        step(4);
        push(0, 0, 1, 26'h000040, 16'h0, 16'hBEEF, 1, 79, 74, -1);
        issue(0, 0, 1, 26'h000040, 16'h0);
        drain(300);
        wait_n = 1'b1;
        step(4);
`endif

        // Reset while in STROBE: no done may follow.
        done_before = n_done;
        issue(0, 1, 0, 26'h000088, 16'h5A5A);
        step(6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rstmid_strobes", {27'b0, ce1_n, ce2_n, oe_n, we_n, reg_n}, 32'h1F);
        check("rstmid_data_oe", {31'b0, bus_data_oe}, 32'd0);
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        step(30);
        check("rstmid_no_done", n_done - done_before, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/pcmcia_bus_arbiter.md
Name: pcmcia_bus_arbiter

Overview:
Shares the single 16-bit PCMCIA/CAM bus between two masters and sequences every access with programmable setup, strobe and hold timing. Requester 0 is the CAM init / CIS-config engine; requester 1 is the EN50221 link-layer memory port. Sits between those masters and the PCMCIA pads, and is the only driver of addr, data, CE, OE, WE and REG.

Parameters:
T_SETUP, 3, cycles with address/REG/CE valid before strobe asserts (min 1)
T_STROBE, 10, minimum cycles OE_n/WE_n held low before wait_n is honoured (min 1)
T_HOLD, 2, cycles with address/data held after strobe deasserts (min 1)
TIMEOUT_CYC, 4096, wait_n low limit in cycles (only with PCMCIA_ARB_TIMEOUT_EN)

Ports:
clk_100mhz  in  1  system clock, 100 MHz
rst  in  1  synchronous active-high reset
req0_valid / req1_valid  in  1  access request; held until reqN_ack
req0_write / req1_write  in  1  1 = write, 0 = read
req0_attr / req1_attr  in  1  1 = attribute memory (REG_n low)
req0_addr / req1_addr  in  26  byte address
req0_wdata / req1_wdata  in  16  write data
req0_ack / req1_ack  out  1  one-cycle pulse: request accepted, inputs captured
req0_done / req1_done  out  1  one-cycle pulse: access complete
rdata  out  16  read data, valid on any reqN_done of a read
err  out  1  qualifies reqN_done; 1 = timed out
bus_addr  out  26  to pcmcia_addr
bus_wdata  out  16  data to pad tristate
bus_data_oe  out  1  drive enable for pcmcia_data
bus_rdata  in  16  pcmcia_data sampled at pads
ce1_n, ce2_n, oe_n, we_n, reg_n  out  1 each  PCMCIA strobes
wait_n  in  1  asynchronous from card
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: all strobes 1, bus_data_oe 0, bus_addr 0, bus_wdata 0, rdata 0, all ack/done/err 0, busy 0, last_grant = 1 (requester 0 wins the first tie).
- wait_n passes through a 2-flop synchroniser (wait_s) before use.
- FSM states: IDLE, SETUP, STROBE, WAIT, HOLD.
- IDLE:
  - If any valid is high, grant by round-robin: on a tie, the requester other than last_grant wins; a lone requester wins.
  - Same cycle: pulse that requester's ack, register its write/attr/addr/wdata, update last_grant, go to SETUP.
- SETUP:
  - Drive bus_addr; reg_n = ~attr; ce1_n = 0; ce2_n = 0 (always 16-bit access).
  - bus_data_oe = write.
  - Counter runs T_SETUP cycles, then go to STROBE.
- STROBE:
  - oe_n = 0 for a read, we_n = 0 for a write.
  - After T_STROBE cycles: if wait_s = 1, go to HOLD; otherwise go to WAIT.
- WAIT:
  - Strobe stays low while wait_s = 0.
  - When wait_s returns to 1, go to HOLD.
- STROBE/WAIT exit:
  - Strobe deasserts on the transition to HOLD.
  - A read captures bus_rdata into rdata on the last strobe-low cycle.
- HOLD:
  - Addr, CE and data_oe are held for T_HOLD cycles.
  - On the final cycle, CE goes to 1, bus_data_oe to 0, and the owner's done pulses; the next cycle is IDLE.
- Timing per access: setup, strobe and hold run back to back and their cycle counts add. Minimum ack→done latency = T_SETUP + T_STROBE + T_HOLD cycles.
- Back-to-back: a new grant is possible in the cycle after done (one IDLE cycle minimum). If both requesters are pending, they alternate.
- Requester withdrawal: a reqN_valid dropped before ack is ignored. Once acked, the access always completes.
- Counters: one 16-bit down-counter shared by all phases, reloaded on every state entry, no wrap.
- Reset mid-access: the FSM returns to IDLE and strobes return high in the next cycle. No done is issued.

Optional Feature:
PCMCIA_ARB_TIMEOUT_EN
- Defined: a counter runs in WAIT. When it reaches TIMEOUT_CYC with wait_s still 0, the strobe is forced high, the FSM goes to HOLD, done pulses with err = 1, and rdata is unchanged.
- Undefined: WAIT is unbounded and err is tied to 0.

Decomposition:
- Shared package pcmcia_pkg:
  - FSM state encoding
  - defaults for T_SETUP, T_STROBE, T_HOLD and TIMEOUT_CYC
  - address width 26 and data width 16
- Sub-module pcmcia_rr_arbiter: 2-way round-robin grant with a last_grant register, which allows future N-way reuse.
- The synchroniser is inline.

Test Plan:
- Single read: req1 read, attr = 1, addr 0x000200, bus_rdata = 0x1D55, wait_n high → reg_n low; oe_n low for 10 cycles; done after 15 cycles; rdata = 0x1D55.
- Single write: req0, addr 0x0003F0, wdata 0x0041 → we_n low for 10 cycles; bus_data_oe high from SETUP through HOLD; bus_wdata stable; reg_n high when attr = 0.
- Contention: both requesters valid continuously → grants alternate 0, 1, 0, 1; each done is followed by exactly one IDLE cycle.
- Wait stretch: wait_n low from STROBE cycle 5 for 40 cycles → oe_n stays low until 2 cycles after wait_n rises (synchroniser delay); no early done.
- Timeout (PCMCIA_ARB_TIMEOUT_EN, TIMEOUT_CYC = 64): wait_n stuck low → done with err = 1, 64 cycles after WAIT entry; strobes released.
- Reset in STROBE: assert rst for 1 cycle → next cycle all strobes = 1, bus_data_oe = 0, busy = 0, no done.
